// File: rtl/pool_wb_rtm_writer.sv
// Pool write-back final stage: skid FIFO for gathered words, registered drain to the
// RTM write port with row-major address generation, done pulse and sticky overflow.
module pool_wb_rtm_writer #(
  parameter int S      = 8,
  parameter int R      = 16,
  parameter int AW     = 16,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 4,
  localparam int DW    = S*R*8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   words_per_row,
  input  logic [AW-1:0] row_stride,
  input  logic [15:0]   n_rows,
  input  logic [DW-1:0] gathered_data,
  input  logic          gathered_vld,
  output logic          wb_afull,
  output logic          rtm_wr_en,
  output logic [AW-1:0] rtm_wr_addr,
  output logic [DW-1:0] rtm_wr_data,
  input  logic          rtm_wr_rdy,
  output logic          busy,
  output logic          done,
  output logic          overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AFL  = CW'(AF_LVL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_nstate;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_occ;      // words held, including the output register
  logic          r_ov;
  logic [DW-1:0] r_od;
  logic          r_ovf;

  logic [15:0]   r_wpr, r_c;
  logic [AW-1:0] r_stride, r_rb;
  logic [31:0]   r_total, r_pushed;

  logic          w_start, w_pop, w_push, w_drop, w_ld, w_mem_rd, w_mem_wr, w_bypass;
  logic          w_last_push;
  logic [CW-1:0] w_mcnt;

  assign w_start     = start && (r_state == S_IDLE);
  assign w_pop       = r_ov && rtm_wr_rdy;
  // A full FIFO still takes a word when the output register drains the same cycle.
  assign w_push      = gathered_vld && (r_state == S_RUN) && ((r_occ != FULL) || w_pop);
  assign w_drop      = gathered_vld && !w_push;
  assign w_mcnt      = r_occ - CW'(r_ov);
  assign w_ld        = !r_ov || w_pop;
  assign w_mem_rd    = w_ld && (w_mcnt != '0);
  assign w_bypass    = w_ld && (w_mcnt == '0) && w_push;
  assign w_mem_wr    = w_push && !w_bypass;
  assign w_last_push = w_push && ((r_pushed + 32'd1) == r_total);

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_nstate = S_RUN;
      S_RUN:   if (w_last_push) w_nstate = S_DRAIN;
      S_DRAIN: if (w_pop && (r_occ == CW'(1))) w_nstate = S_DONE;
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[r_wp] <= gathered_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
      r_ov  <= 1'b0;
      r_od  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_drop;
      if (w_mem_wr) r_wp <= r_wp + PW'(1);
      if (w_mem_rd) r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: ;
      endcase
      // Output register only reloads when empty or being accepted, so it holds under stall.
      if (w_ld) begin
        r_ov <= w_mem_rd | w_bypass;
        if (w_mem_rd)      r_od <= r_mem[r_rp];
        else if (w_bypass) r_od <= gathered_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wpr    <= '0;
      r_stride <= '0;
      r_total  <= '0;
      r_pushed <= '0;
      r_c      <= '0;
      r_rb     <= '0;
    end else if (w_start) begin
      r_wpr    <= words_per_row;
      r_stride <= row_stride;
      r_total  <= 32'(n_rows) * 32'(words_per_row);
      r_pushed <= '0;
      r_c      <= '0;
      r_rb     <= base_addr;
    end else begin
      if (w_push) r_pushed <= r_pushed + 32'd1;
      if (w_pop) begin
        if (r_c == (r_wpr - 16'd1)) begin
          r_c  <= '0;
          r_rb <= r_rb + r_stride;
        end else begin
          r_c  <= r_c + 16'd1;
        end
      end
    end
  end

  assign wb_afull    = (r_occ >= AFL);
  assign rtm_wr_en   = r_ov;
  assign rtm_wr_addr = r_ov ? (r_rb + AW'(r_c)) : '0;
  assign rtm_wr_data = r_od;
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_pool_wb_rtm_writer.sv
// Scoreboard bench for pool_wb_rtm_writer: directed jobs push expected {addr,data};
// a negedge monitor pops and compares on every accepted RTM write.
module tb_pool_wb_rtm_writer;
  localparam int AW = 16;
  localparam int DW = 8*16*8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   words_per_row = '0;
  logic [AW-1:0] row_stride = '0;
  logic [15:0]   n_rows = '0;
  logic [DW-1:0] gathered_data = '0;
  logic          gathered_vld = 1'b0;
  logic          wb_afull, rtm_wr_en, busy, done, overflow;
  logic [AW-1:0] rtm_wr_addr;
  logic [DW-1:0] rtm_wr_data;
  logic          rtm_wr_rdy = 1'b0;

  pool_wb_rtm_writer #(.S(8), .R(16), .AW(AW), .DEPTH(8), .AF_LVL(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .words_per_row(words_per_row), .row_stride(row_stride), .n_rows(n_rows),
    .gathered_data(gathered_data), .gathered_vld(gathered_vld), .wb_afull(wb_afull),
    .rtm_wr_en(rtm_wr_en), .rtm_wr_addr(rtm_wr_addr), .rtm_wr_data(rtm_wr_data),
    .rtm_wr_rdy(rtm_wr_rdy), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int n_wr = 0, job_words = 0, done_cnt = 0;
  bit mon_en = 0, done_due = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  function automatic logic [DW-1:0] pat(input int idx);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = 32'hC0DE0000 ^ (k << 8) ^ idx;
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (done || done_due) chk("done_timing", 64'(done), 64'(done_due));
      if (done) done_cnt++;
      done_due = 0;
      if (prev_stall) begin
        checks++;
        if (!(rtm_wr_en && rtm_wr_addr == prev_addr && rtm_wr_data == prev_data)) begin
          errors++;
          $display("FAIL stall_hold: en=%0b addr=%0h expected addr=%0h held", rtm_wr_en, rtm_wr_addr, prev_addr);
        end
      end
      prev_stall = rtm_wr_en && !rtm_wr_rdy;
      prev_addr  = rtm_wr_addr;
      prev_data  = rtm_wr_data;
      if (rtm_wr_en && rtm_wr_rdy) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr=%0h expected no write", rtm_wr_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", 64'(rtm_wr_addr), 64'(e.addr));
          checks++;
          if (rtm_wr_data !== e.data) begin
            errors++;
            $display("FAIL wr_data: got lo %0h expected lo %0h", rtm_wr_data[63:0], e.data[63:0]);
          end
        end
        n_wr++;
        if (n_wr == job_words) done_due = 1;
      end
    end
  end

  task automatic do_reset();
    mon_en = 0;
    rstn = 1'b0; gathered_vld = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete(); n_wr = 0; done_due = 0; prev_stall = 0;
    #1 rstn = 1'b1;
    mon_en = 1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [15:0] wpr,
                           input logic [AW-1:0] str, input logic [15:0] rows);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; words_per_row = wpr; row_stride = str; n_rows = rows;
    @(posedge clk); #1;
    start = 1'b0;
    job_words = int'(wpr) * int'(rows);
    n_wr = 0;
  endtask

  // Drive one word for one cycle; caller is #1 after a posedge and returns likewise.
  task automatic push(input int idx, input logic [AW-1:0] a, input bit expect_it);
    if (expect_it) sb.push_back('{addr: a, data: pat(idx)});
    gathered_vld = 1'b1; gathered_data = pat(idx);
    @(posedge clk); #1;
    gathered_vld = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_wr >= n) break;
    end
    if (i == 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: writes %0d expected %0d", name, n_wr, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] a_t1 [8] = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h108, 16'h109, 16'h10A, 16'h10B};
  logic [AW-1:0] a_t3 [8] = '{16'h200, 16'h201, 16'h202, 16'h210, 16'h211, 16'h212, 16'h220, 16'h221};
  logic [AW-1:0] a_t4 [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [AW-1:0] a_t6 [4] = '{16'h300, 16'h301, 16'h304, 16'h305};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_en", 64'(rtm_wr_en), 0);
    chk("rst_addr", 64'(rtm_wr_addr), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_afull", 64'(wb_afull), 0);
    chk("rst_ovf", 64'(overflow), 0);

    // T1: back-to-back, rdy=1
    rtm_wr_rdy = 1'b1;
    start_job(16'h100, 16'd4, 16'd8, 16'd2);
    chk("t1_busy", 64'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{addr: a_t1[i], data: pat(i)});
      gathered_vld = 1'b1; gathered_data = pat(i);
      @(posedge clk); #1;
      if (i == 0) chk("t1_latency", 64'(rtm_wr_en), 1);
    end
    gathered_vld = 1'b0;
    wait_writes(8, "t1");
    chk("t1_done_cnt", 64'(done_cnt), 1);
    chk("t1_ovf", 64'(overflow), 0);
    chk("t1_idle", 64'(busy), 0);

    // T2: rdy=0 for the first 10 cycles of the job
    rtm_wr_rdy = 1'b0;
    start_job(16'h100, 16'd4, 16'd8, 16'd2);
    for (int i = 0; i < 8; i++) begin
      push(100 + i, a_t1[i], 1);
      chk($sformatf("t2_afull_%0d", i + 1), 64'(wb_afull), 64'((i + 1) >= 4));
    end
    repeat (1) @(posedge clk); #1;
    chk("t2_en_stalled", 64'(rtm_wr_en), 1);
    rtm_wr_rdy = 1'b1;
    wait_writes(8, "t2");
    chk("t2_done_cnt", 64'(done_cnt), 2);
    chk("t2_ovf", 64'(overflow), 0);
    chk("t2_afull_end", 64'(wb_afull), 0);

    // T3: 9 words into an 8-deep FIFO with rdy=0
    rtm_wr_rdy = 1'b0;
    start_job(16'h200, 16'd3, 16'h10, 16'd3);
    for (int i = 0; i < 9; i++) begin
      push(200 + i, (i < 8) ? a_t3[i] : 16'h0, i < 8);
      if (i == 7) chk("t3_ovf_before", 64'(overflow), 0);
    end
    chk("t3_ovf_set", 64'(overflow), 1);
    rtm_wr_rdy = 1'b1;
    wait_writes(8, "t3");
    chk("t3_writes", 64'(n_wr), 8);
    chk("t3_empty", 64'(rtm_wr_en), 0);
    chk("t3_ovf_sticky", 64'(overflow), 1);
    do_reset();
    chk("t3_ovf_cleared", 64'(overflow), 0);

    // T4: address wrap past 0xFFFF
    rtm_wr_rdy = 1'b1;
    start_job(16'hFFFE, 16'd4, 16'd0, 16'd1);
    for (int i = 0; i < 4; i++) push(300 + i, a_t4[i], 1);
    wait_writes(4, "t4");
    chk("t4_done_cnt", 64'(done_cnt), 3);

    // T5: async reset after 3 writes
    start_job(16'h100, 16'd4, 16'd8, 16'd2);
    for (int i = 0; i < 4; i++) push(400 + i, a_t1[i], 1);
    chk("t5_three_written", 64'(n_wr), 3);
    mon_en = 0;
    rstn = 1'b0;
    #1;
    chk("t5_rst_en", 64'(rtm_wr_en), 0);
    chk("t5_rst_addr", 64'(rtm_wr_addr), 0);
    chk("t5_rst_data", rtm_wr_data[63:0], 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_done", 64'(done), 0);
    do_reset();
    start_job(16'h100, 16'd4, 16'd8, 16'd2);
    for (int i = 0; i < 8; i++) push(500 + i, a_t1[i], 1);
    wait_writes(8, "t5");
    chk("t5_done_cnt", 64'(done_cnt), 4);

    // T6: vld in IDLE, start during RUN
    push(600, 16'h0, 0);
    chk("t6_ovf_idle", 64'(overflow), 1);
    start_job(16'h300, 16'd2, 16'd4, 16'd2);
    push(601, a_t6[0], 1);
    start = 1'b1; base_addr = 16'h500; words_per_row = 16'd1; row_stride = 16'h40; n_rows = 16'd9;
    push(602, a_t6[1], 1);
    start = 1'b0;
    push(603, a_t6[2], 1);
    push(604, a_t6[3], 1);
    wait_writes(4, "t6");
    chk("t6_done_cnt", 64'(done_cnt), 5);
    chk("t6_ovf_sticky", 64'(overflow), 1);
    chk("t6_sb_empty", 64'(sb.size()), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
